// File: rtl/ham_pkg.sv
// Shared types and width helpers for the min/max Hamming distance engine.
// Pure definitions: no logic, no latency, no flow control.
package ham_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPARE,
      S_WR_MIN,
      S_WR_MAX,
      S_DONE
   } state_e;

   function automatic int dw(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic int iw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int n_pairs(input int n);
      return n * (n - 1) / 2;
   endfunction

endpackage

// File: rtl/hamming_minmax_engine_popcount.sv
// Combinational population count of a W-bit vector.
// Zero latency; no flow control.
module popcount #(
   parameter  int W  = 16,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  data_i,
   output logic [CW-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int k = 0; k < W; k++) begin
         count_o = count_o + CW'(data_i[k]);
      end
   end

endmodule

// File: rtl/hamming_minmax_engine.sv
// Loads N_WORDS operands byte-wise, scans all pairs for min/max Hamming distance, writes both back.
// Run length N*B + N(N-1)/2 + 3 cycles; start is ignored while busy.
module hamming_minmax_engine
   import ham_pkg::*;
#(
   parameter  int WORD_W    = 16,
   parameter  int N_WORDS   = 32,
   parameter  int ADDR_W    = 8,
   parameter  int OPND_BASE = 0,
   parameter  int MIN_ADDR  = 64,
   parameter  int MAX_ADDR  = 65,
   localparam int DW        = dw(WORD_W),
   localparam int IW        = iw(N_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   output logic [DW-1:0]     min_dist,
   output logic [DW-1:0]     max_dist,
   output logic [IW-1:0]     min_i,
   output logic [IW-1:0]     min_j,
   output logic [IW-1:0]     max_i,
   output logic [IW-1:0]     max_j
);

   localparam int B  = WORD_W / 8;
   localparam int NP = n_pairs(N_WORDS);
   localparam int PW = $clog2(NP + 1);

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   cache_q [N_WORDS];
   logic [IW-1:0]       ld_word_q;
   logic [3:0]          ld_byte_q;
   logic [IW-1:0]       i_q, j_q, pi_q, pj_q;
   logic [PW-1:0]       pairs_left_q;
   logic                pvld_q;
   logic [DW-1:0]       dist_q, pc_cnt;
   logic [DW-1:0]       min_q, max_q;
   logic [IW-1:0]       min_i_q, min_j_q, max_i_q, max_j_q;
   logic                accept, ld_last, first_pair;
   logic [WORD_W-1:0]   pair_xor;

   assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);
   assign ld_last    = (ld_word_q == IW'(N_WORDS - 1)) && (ld_byte_q == 4'(B - 1));
   assign first_pair = (pi_q == '0) && (pj_q == IW'(1));
   assign pair_xor   = cache_q[i_q] ^ cache_q[j_q];

   popcount #(.W(WORD_W)) u_popcount (
      .data_i  (pair_xor),
      .count_o (pc_cnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      done        = 1'b0;
      busy        = 1'b0;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      case (state_q)
         S_IDLE: if (start) state_d = S_LOAD;
         S_LOAD: begin
            busy     = 1'b1;
            mem_addr = ADDR_W'(OPND_BASE + int'(ld_word_q) * B + int'(ld_byte_q));
            if (ld_last) state_d = S_COMPARE;
         end
         // One extra drain cycle lets the registered last distance reach min/max.
         S_COMPARE: begin
            busy = 1'b1;
            if (pairs_left_q == '0) state_d = S_WR_MIN;
         end
         S_WR_MIN: begin
            busy        = 1'b1;
            mem_wr_en   = 1'b1;
            mem_addr    = ADDR_W'(MIN_ADDR);
            mem_wr_data = 8'(min_q);
            state_d     = S_WR_MAX;
         end
         S_WR_MAX: begin
            busy        = 1'b1;
            mem_wr_en   = 1'b1;
            mem_addr    = ADDR_W'(MAX_ADDR);
            mem_wr_data = 8'(max_q);
            state_d     = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state_q == S_LOAD) begin
         cache_q[ld_word_q][(B - 1 - int'(ld_byte_q)) * 8 +: 8] <= mem_rd_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_word_q    <= '0;
         ld_byte_q    <= '0;
         i_q          <= '0;
         j_q          <= '0;
         pi_q         <= '0;
         pj_q         <= '0;
         pairs_left_q <= '0;
         pvld_q       <= 1'b0;
         dist_q       <= '0;
         min_q        <= DW'(WORD_W);
         max_q        <= '0;
         min_i_q      <= '0;
         min_j_q      <= '0;
         max_i_q      <= '0;
         max_j_q      <= '0;
      end else begin
         pvld_q <= (state_q == S_COMPARE) && (pairs_left_q != '0);
         if (accept) begin
            ld_word_q    <= '0;
            ld_byte_q    <= '0;
            i_q          <= '0;
            j_q          <= IW'(1);
            pairs_left_q <= PW'(NP);
            min_q        <= DW'(WORD_W);
            max_q        <= '0;
            min_i_q      <= '0;
            min_j_q      <= '0;
            max_i_q      <= '0;
            max_j_q      <= '0;
         end
         if (state_q == S_LOAD) begin
            if (ld_byte_q == 4'(B - 1)) begin
               ld_byte_q <= '0;
               ld_word_q <= ld_word_q + IW'(1);
            end else begin
               ld_byte_q <= ld_byte_q + 4'd1;
            end
         end
         if (state_q == S_COMPARE && pairs_left_q != '0) begin
            dist_q       <= pc_cnt;
            pi_q         <= i_q;
            pj_q         <= j_q;
            pairs_left_q <= pairs_left_q - PW'(1);
            if (j_q == IW'(N_WORDS - 1)) begin
               i_q <= i_q + IW'(1);
               j_q <= i_q + IW'(2);
            end else begin
               j_q <= j_q + IW'(1);
            end
         end
         // Strict compares keep the lexicographically earliest pair on ties.
         if (pvld_q) begin
            if (first_pair || dist_q < min_q) begin
               min_q   <= dist_q;
               min_i_q <= pi_q;
               min_j_q <= pj_q;
            end
            if (first_pair || dist_q > max_q) begin
               max_q   <= dist_q;
               max_i_q <= pi_q;
               max_j_q <= pj_q;
            end
         end
      end
   end

   assign min_dist = min_q;
   assign max_dist = max_q;
   assign min_i    = min_i_q;
   assign min_j    = min_j_q;
   assign max_i    = max_i_q;
   assign max_j    = max_j_q;

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Directed bench for hamming_minmax_engine: default 16x32 instance plus a 32x4 instance.
module tb_hamming_minmax_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic       start0, done0, busy0, wen0;
   logic [7:0] addr0, rdat0, wdat0;
   logic [4:0] mind0, maxd0, mini0, minj0, maxi0, maxj0;

   logic       start1, done1, busy1, wen1;
   logic [7:0] addr1, rdat1, wdat1;
   logic [5:0] mind1, maxd1;
   logic [1:0] mini1, minj1, maxi1, maxj1;

   logic [7:0]  omem0 [256];
   logic [7:0]  omem1 [256];
   logic [15:0] wlog0 [64];
   logic [15:0] wlog1 [64];
   int          wcnt0 = 0;
   int          wcnt1 = 0;
   logic [15:0] words0 [32];

   int n_chk  = 0;
   int n_fail = 0;

   assign rdat0 = omem0[addr0];
   assign rdat1 = omem1[addr1];

   always @(posedge clk) begin
      if (wen0 === 1'b1) begin
         wlog0[wcnt0 % 64] <= {addr0, wdat0};
         wcnt0 <= wcnt0 + 1;
      end
      if (wen1 === 1'b1) begin
         wlog1[wcnt1 % 64] <= {addr1, wdat1};
         wcnt1 <= wcnt1 + 1;
      end
   end

   hamming_minmax_engine u_dut0 (
      .clk(clk), .reset(rst), .start(start0), .done(done0), .busy(busy0),
      .mem_addr(addr0), .mem_rd_data(rdat0), .mem_wr_en(wen0), .mem_wr_data(wdat0),
      .min_dist(mind0), .max_dist(maxd0), .min_i(mini0), .min_j(minj0),
      .max_i(maxi0), .max_j(maxj0)
   );

   hamming_minmax_engine #(.WORD_W(32), .N_WORDS(4)) u_dut1 (
      .clk(clk), .reset(rst), .start(start1), .done(done1), .busy(busy1),
      .mem_addr(addr1), .mem_rd_data(rdat1), .mem_wr_en(wen1), .mem_wr_data(wdat1),
      .min_dist(mind1), .max_dist(maxd1), .min_i(mini1), .min_j(minj1),
      .max_i(maxi1), .max_j(maxj1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load0();
      for (int w = 0; w < 32; w++) begin
         omem0[2*w]   = words0[w][15:8];
         omem0[2*w+1] = words0[w][7:0];
      end
   endtask

   // Brute-force reference over all unordered pairs.
   task automatic model0(output int mn, output int mi, output int mj,
                         output int mx, output int xi, output int xj);
      mn = 0; mi = 0; mj = 0; mx = 0; xi = 0; xj = 0;
      for (int i = 0; i < 32; i++) begin
         for (int j = i + 1; j < 32; j++) begin
            int d;
            d = $countones(words0[i] ^ words0[j]);
            if (i == 0 && j == 1) begin
               mn = d; mi = i; mj = j; mx = d; xi = i; xj = j;
            end else begin
               if (d < mn) begin mn = d; mi = i; mj = j; end
               if (d > mx) begin mx = d; xi = i; xj = j; end
            end
         end
      end
   endtask

   task automatic check_res0(input string tag, input int mn, input int mi, input int mj,
                             input int mx, input int xi, input int xj, input int base);
      check_eq({tag, "_min"},   64'(mind0), 64'(mn));
      check_eq({tag, "_min_i"}, 64'(mini0), 64'(mi));
      check_eq({tag, "_min_j"}, 64'(minj0), 64'(mj));
      check_eq({tag, "_max"},   64'(maxd0), 64'(mx));
      check_eq({tag, "_max_i"}, 64'(maxi0), 64'(xi));
      check_eq({tag, "_max_j"}, 64'(maxj0), 64'(xj));
      check_eq({tag, "_nwr"},   64'(wcnt0 - base), 64'd2);
      check_eq({tag, "_wr_min"}, 64'(wlog0[base % 64]),       64'(16'h4000 + mn));
      check_eq({tag, "_wr_max"}, 64'(wlog0[(base + 1) % 64]), 64'(16'h4100 + mx));
      check_eq({tag, "_busy_end"}, 64'(busy0), 64'd0);
   endtask

   task automatic run0(input bit keep, input bit toggle, output int edges);
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) start0 = 1'b0;
      check_eq("busy_after_start", 64'(busy0), 64'd1);
      edges = 0;
      while (done0 !== 1'b1 && edges < 3000) begin
         @(posedge clk);
         #1;
         edges++;
         if (toggle) start0 = (edges >= 100 && edges < 110) && edges[0];
      end
   endtask

   initial begin
      int e, base, mn, mi, mj, mx, xi, xj;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      for (int a = 0; a < 256; a++) begin
         omem0[a] = 8'h00;
         omem1[a] = 8'h00;
      end
      #12;
      check_eq("rst_done",  64'(done0), 64'd0);
      check_eq("rst_busy",  64'(busy0), 64'd0);
      check_eq("rst_wen",   64'(wen0),  64'd0);
      check_eq("rst_addr",  64'(addr0), 64'd0);
      check_eq("rst_wdat",  64'(wdat0), 64'd0);
      check_eq("rst_min",   64'(mind0), 64'd16);
      check_eq("rst_max",   64'(maxd0), 64'd0);
      check_eq("rst_idx",   64'({mini0, minj0, maxi0, maxj0}), 64'd0);
      check_eq("rst1_min",  64'(mind1), 64'd32);
      @(negedge clk);
      rst = 1'b0;

      // All-zero operands
      for (int w = 0; w < 32; w++) words0[w] = 16'h0000;
      load0();
      base = wcnt0;
      run0(1'b0, 1'b0, e);
      check_eq("t1_latency", 64'(e), 64'd563);
      check_res0("t1", 0, 0, 1, 0, 0, 1, base);

      // Two all-ones words among zeros
      words0[5] = 16'hFFFF;
      words0[9] = 16'hFFFF;
      load0();
      base = wcnt0;
      run0(1'b0, 1'b0, e);
      check_eq("t2_latency", 64'(e), 64'd563);
      check_res0("t2", 0, 0, 1, 16, 0, 5, base);

      // Random operands against the reference model
      for (int w = 0; w < 32; w++) words0[w] = 16'($urandom);
      load0();
      model0(mn, mi, mj, mx, xi, xj);
      base = wcnt0;
      run0(1'b0, 1'b0, e);
      check_eq("t3_latency", 64'(e), 64'd563);
      check_res0("t3", mn, mi, mj, mx, xi, xj, base);

      // Reset pulsed mid-run, then a clean rerun
      base = wcnt0;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      repeat (200) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("t4_rst_busy", 64'(busy0), 64'd0);
      check_eq("t4_rst_done", 64'(done0), 64'd0);
      check_eq("t4_rst_addr", 64'(addr0), 64'd0);
      check_eq("t4_rst_min",  64'(mind0), 64'd16);
      check_eq("t4_rst_max",  64'(maxd0), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (600) @(posedge clk);
      #1;
      check_eq("t4_no_writes", 64'(wcnt0 - base), 64'd0);
      check_eq("t4_idle_done", 64'(done0), 64'd0);
      base = wcnt0;
      run0(1'b0, 1'b0, e);
      check_eq("t4_latency", 64'(e), 64'd563);
      check_res0("t4", mn, mi, mj, mx, xi, xj, base);

      // start toggled during COMPARE
      base = wcnt0;
      run0(1'b0, 1'b1, e);
      check_eq("t5_latency", 64'(e), 64'd563);
      check_res0("t5", mn, mi, mj, mx, xi, xj, base);

      // start held across DONE: back-to-back runs
      base = wcnt0;
      run0(1'b1, 1'b0, e);
      check_eq("t6a_latency", 64'(e), 64'd563);
      check_res0("t6a", mn, mi, mj, mx, xi, xj, base);
      base = wcnt0;
      @(posedge clk);
      #1;
      check_eq("t6_restart_done", 64'(done0), 64'd0);
      check_eq("t6_restart_busy", 64'(busy0), 64'd1);
      start0 = 1'b0;
      e = 0;
      while (done0 !== 1'b1 && e < 3000) begin
         @(posedge clk);
         #1;
         e++;
      end
      check_eq("t6b_latency", 64'(e), 64'd563);
      check_res0("t6b", mn, mi, mj, mx, xi, xj, base);

      // 32-bit x 4 instance
      for (int b = 4; b < 8; b++) omem1[b] = 8'hFF;
      omem1[10] = 8'hFF; omem1[11] = 8'hFF;
      omem1[14] = 8'hFF; omem1[15] = 8'hFF;
      base = wcnt1;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      e = 0;
      while (done1 !== 1'b1 && e < 500) begin
         @(posedge clk);
         #1;
         e++;
      end
      check_eq("w32_latency", 64'(e), 64'd25);
      check_eq("w32_min",   64'(mind1), 64'd0);
      check_eq("w32_min_i", 64'(mini1), 64'd2);
      check_eq("w32_min_j", 64'(minj1), 64'd3);
      check_eq("w32_max",   64'(maxd1), 64'd32);
      check_eq("w32_max_i", 64'(maxi1), 64'd0);
      check_eq("w32_max_j", 64'(maxj1), 64'd1);
      check_eq("w32_nwr",   64'(wcnt1 - base), 64'd2);
      check_eq("w32_wr_min", 64'(wlog1[base % 64]),       64'h4000);
      check_eq("w32_wr_max", 64'(wlog1[(base + 1) % 64]), 64'h4120);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
